seven_segment_scan_controller: RTL and testbench

// Time-multiplexes DIGITS BCD digits onto one shared BcdSevenSegment decoder.

---
 rtl/seven_segment_scan_controller.sv | 173 +++++++++++++++++
 tb/tb_seven_segment_scan_controller.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scan_controller.sv
// Multiplexed BCD display scanner with dead-time blanking between digits,
// double-buffered digit data and optional leading-zero blanking.
module seven_segment_scan_controller #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  lzb,
    output logic [3:0]            bcd_out,
    output logic                  n_dec_enable,
    output logic [DIGITS-1:0]     anode,
    output logic                  dp_out,
    output logic                  frame_tick
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DIGITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [CNT_W-1:0] SHOW_END  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [4*DIGITS-1:0]  pend_q, pend_d;
    logic [4*DIGITS-1:0]  act_q, act_d;
    logic [DIGITS-1:0]    pdp_q, pdp_d;
    logic [DIGITS-1:0]    adp_q, adp_d;
    logic                 pflag_q, pflag_d;
    logic                 boundary;

    logic                 upper_zero;
    logic                 lit_d;
    logic [3:0]           bcd_d;
    logic                 dp_d;
    logic [DIGITS-1:0]    anode_d;
    logic                 tick_d;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q + CNT_ONE;
        boundary = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (enable) begin
                    state_d  = BLANK;
                    boundary = 1'b1;
                end
            end
            BLANK: begin
                if (cnt_q == BLANK_END) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                end
            end
            SHOW: begin
                if (cnt_q == SHOW_END) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    if (idx_q == LAST_IDX) begin
                        idx_d    = '0;
                        boundary = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (!enable) begin
            state_d  = IDLE;
            idx_d    = '0;
            cnt_d    = '0;
            boundary = 1'b0;
        end
    end

    // A load landing on a frame boundary bypasses the pending buffer.
    always_comb begin
        pend_d  = pend_q;
        pdp_d   = pdp_q;
        act_d   = act_q;
        adp_d   = adp_q;
        pflag_d = pflag_q;
        if (boundary) begin
            if (load) begin
                act_d = bcd_in;
                adp_d = dp_in;
            end else if (pflag_q) begin
                act_d = pend_q;
                adp_d = pdp_q;
            end
            pflag_d = 1'b0;
        end else if (load) begin
            pend_d  = bcd_in;
            pdp_d   = dp_in;
            pflag_d = 1'b1;
        end
    end

    always_comb begin
        upper_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (i >= int'(idx_d) && act_d[4*i +: 4] != 4'd0) begin
                upper_zero = 1'b0;
            end
        end
        lit_d   = (state_d == SHOW) &&
                  !(lzb && idx_d != '0 && upper_zero);
        anode_d = '0;
        if (lit_d) begin
            anode_d[idx_d] = 1'b1;
        end
        bcd_d  = act_d[{idx_d, 2'b00} +: 4];
        dp_d   = adp_d[idx_d];
        if (state_d == IDLE) begin
            bcd_d = '0;
            dp_d  = 1'b0;
        end
        tick_d = (state_d == SHOW) && (cnt_d == SHOW_END) &&
                 (idx_d == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            pend_q       <= '0;
            pdp_q        <= '0;
            act_q        <= '0;
            adp_q        <= '0;
            pflag_q      <= 1'b0;
            bcd_out      <= '0;
            dp_out       <= 1'b0;
            anode        <= '0;
            n_dec_enable <= 1'b1;
            frame_tick   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            pdp_q        <= pdp_d;
            act_q        <= act_d;
            adp_q        <= adp_d;
            pflag_q      <= pflag_d;
            bcd_out      <= bcd_d;
            dp_out       <= dp_d;
            anode        <= anode_d;
            n_dec_enable <= !lit_d;
            frame_tick   <= tick_d;
        end
    end

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Bench for seven_segment_scan_controller: directed scenarios plus random
// traffic, checked every cycle against a time-based display model.
module tb_seven_segment_scan_controller;

    localparam int D  = 4;
    localparam int S  = 8;
    localparam int B  = 2;
    localparam int SL = B + S;
    localparam int FR = D * SL;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          load;
    logic [15:0]   bcd_in;
    logic [3:0]    dp_in;
    logic          lzb;
    logic [3:0]    bcd_out;
    logic          n_dec_enable;
    logic [3:0]    anode;
    logic          dp_out;
    logic          frame_tick;

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit          m_run;
    int          m_t;
    logic [15:0] m_act, m_pend;
    logic [3:0]  m_adp, m_pdp;
    bit          m_pf;

    seven_segment_scan_controller #(
        .DIGITS(D), .SCAN_DIV(S), .BLANK_CYCLES(B), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .load(load),
        .bcd_in(bcd_in), .dp_in(dp_in), .lzb(lzb),
        .bcd_out(bcd_out), .n_dec_enable(n_dec_enable),
        .anode(anode), .dp_out(dp_out), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit bnd;
        if (rst) begin
            m_run = 0; m_t = 0; m_pf = 0;
            m_act = '0; m_pend = '0; m_adp = '0; m_pdp = '0;
        end else begin
            bnd = 0;
            if (!enable) begin
                m_run = 0;
            end else if (!m_run) begin
                m_run = 1; m_t = 0; bnd = 1;
            end else begin
                m_t++;
                bnd = (m_t % FR == 0);
            end
            if (bnd) begin
                if (load) begin
                    m_act = bcd_in; m_adp = dp_in;
                end else if (m_pf) begin
                    m_act = m_pend; m_adp = m_pdp;
                end
                m_pf = 0;
            end else if (load) begin
                m_pend = bcd_in; m_pdp = dp_in; m_pf = 1;
            end
        end
    endtask

    task automatic step();
        int          slot, pos;
        bit          blanked, lit;
        logic [3:0]  e_an, e_bcd;
        logic        e_dp, e_ft;
        @(posedge clk);
        model_edge();
        #1;
        e_an = '0; e_bcd = '0; e_dp = 0; e_ft = 0; lit = 0;
        if (m_run) begin
            slot    = (m_t / SL) % D;
            pos     = m_t % SL;
            blanked = lzb && slot != 0 && ((m_act >> (4 * slot)) == 16'd0);
            lit     = (pos >= B) && !blanked;
            e_an    = lit ? 4'(1 << slot) : 4'd0;
            e_bcd   = 4'((m_act >> (4 * slot)) & 16'hF);
            e_dp    = m_adp[slot];
            e_ft    = ((m_t + 1) % FR == 0);
        end
        chk("anode", 32'(anode), 32'(e_an));
        chk("n_dec_enable", 32'(n_dec_enable), 32'(!lit));
        chk("bcd_out", 32'(bcd_out), 32'(e_bcd));
        chk("dp_out", 32'(dp_out), 32'(e_dp));
        chk("frame_tick", 32'(frame_tick), 32'(e_ft));
        chk("onehot0", 32'($onehot0(anode)), 32'd1);
        chk("anode_implies_en", 32'(anode != 0 && n_dec_enable), 32'd0);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        bcd_in = v; dp_in = d; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; enable = 1'b0; load = 1'b0;
        bcd_in = '0; dp_in = '0; lzb = 1'b0;
        m_run = 0; m_t = 0; m_pf = 0;
        m_act = '0; m_pend = '0; m_adp = '0; m_pdp = '0;
        repeat (2) step();
        chk("reset_anode", 32'(anode), 32'd0);
        chk("reset_nen", 32'(n_dec_enable), 32'd1);
        rst = 1'b0;

        // 1: basic scan of 1234
        do_load(16'h1234, 4'b0010);
        enable = 1'b1;
        repeat (2 * FR) step();

        // 2: mid-frame load takes effect at the next frame
        repeat (13) step();
        do_load(16'h5678, 4'b1000);
        repeat (2 * FR) step();

        // 3: leading-zero blanking
        lzb = 1'b1;
        do_load(16'h0005, 4'b0000);
        repeat (2 * FR) step();
        do_load(16'h0000, 4'b0001);
        repeat (2 * FR) step();
        do_load(16'h0050, 4'b0000);
        repeat (FR + 5) step();
        lzb = 1'b0;

        // 4: load on the frame_tick cycle goes straight to the next frame
        n = 0;
        while (!frame_tick && n < 2 * FR) begin step(); n++; end
        chk("ft_wait", 32'(frame_tick), 32'd1);
        do_load(16'h9999, 4'b0101);
        repeat (2 * FR) step();

        // 5: drop enable during SHOW, then restart
        n = 0;
        while (n_dec_enable && n < 2 * FR) begin step(); n++; end
        chk("show_wait", 32'(n_dec_enable), 32'd0);
        enable = 1'b0;
        step();
        chk("disable_dark", 32'(anode), 32'd0);
        repeat (5) step();
        enable = 1'b1;
        repeat (FR + 3) step();

        // 6: reset during SHOW of digit 2
        n = 0;
        while (anode != 4'b0100 && n < 2 * FR) begin step(); n++; end
        chk("digit2_wait", 32'(anode), 32'h4);
        rst = 1'b1; enable = 1'b0;
        step();
        rst = 1'b0;
        repeat (20) step();
        do_load(16'h4321, 4'b0011);
        enable = 1'b1;
        repeat (FR + 3) step();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rst    = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 99) == 0) enable = ~enable;
            if ($urandom_range(0, 49) == 0) lzb = ~lzb;
            load   = ($urandom_range(0, 7) == 0);
            bcd_in = 16'($urandom);
            if ($urandom_range(0, 1) == 0) bcd_in[15:8] = 8'h00;
            dp_in  = 4'($urandom);
            step();
        end
        rst = 1'b0; load = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
